// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared encodings for the 3-stage hazard scheduler:
//     - forwarding-select encodings (FWD_NONE / FWD_X / FWD_W)
//     - scheduler FSM states (RUN / LDSTALL / FLUSH / MEMWAIT)
//     - shadow-entry flag struct and counter widths
//   The X/W shadow rd field is sized by the REG_AW parameter of the users.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    // Operand source for the D-stage register read
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,   // regfile
        FWD_X    = 2'd1,   // X-stage ALU result
        FWD_W    = 2'd2    // W-stage writeback data
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2,
        MEMWAIT = 2'd3
    } hz_state_e;

    // Per-stage shadow flags; the rd field lives beside it (width REG_AW)
    typedef struct packed {
        logic valid;
        logic we;      // already forced low for rd == 0
        logic load;
        logic mem;
    } sh_flags_t;

    localparam int TMO_W       = 8;   // memory-timeout counter width
    localparam int FLUSH_CNT_W = 2;   // enough for FLUSH_CYCLES up to 3

endpackage

// File: rtl/hazard_fwd_match.sv
// -----------------------------------------------------------------------------
// hazard_fwd_match
//   Per-operand comparator of one D-stage source against the X and W shadows.
//   Ports:
//     use_rs, rs                  - D instruction reads register rs
//     x_valid, x_we, x_load, x_rd - X shadow entry
//     w_valid, w_we, w_rd         - W shadow entry
//     sel                         - forwarding select (fwd_sel_e encoding)
//     raw_hit                     - this operand needs the D stage held
//   Build option HAZARD_FWD_EN:
//     defined   - X (non-load) beats W forwarding; only a load in X stalls.
//     undefined - sel is always FWD_NONE; any X or W writer match stalls.
// -----------------------------------------------------------------------------
module hazard_fwd_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
)(
    input  logic              use_rs,
    input  logic [REG_AW-1:0] rs,
    input  logic              x_valid,
    input  logic              x_we,
    input  logic              x_load,
    input  logic [REG_AW-1:0] x_rd,
    input  logic              w_valid,
    input  logic              w_we,
    input  logic [REG_AW-1:0] w_rd,
    output logic [1:0]        sel,
    output logic              raw_hit
);

    logic src_live;
    logic x_alu_hit;
    logic x_ld_hit;
    logic w_hit;

    // x0 is hard-wired zero, so it never creates a dependency
    assign src_live  = use_rs && (rs != '0);
    assign x_alu_hit = src_live && x_valid && x_we && !x_load && (x_rd == rs);
    assign x_ld_hit  = src_live && x_valid && x_we &&  x_load && (x_rd == rs);
    assign w_hit     = src_live && w_valid && w_we && (w_rd == rs);

`ifdef HAZARD_FWD_EN
    // Load data is not available until W, so a load in X cannot forward
    assign sel     = x_alu_hit ? FWD_X : (w_hit ? FWD_W : FWD_NONE);
    assign raw_hit = x_ld_hit;
`else
    assign sel     = FWD_NONE;
    assign raw_hit = x_alu_hit || x_ld_hit || w_hit;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central hazard scheduler for the D / X / W RISC-V pipeline. Keeps shadow
//   copies of the X and W instruction attributes and produces forwarding
//   selects, load-use (or generic RAW) stalls, redirect flush bubbles and a
//   full-pipe freeze while data memory is busy.
//   Ports:
//     clk, rst_n                          - clock, async active-low reset
//     d_valid, d_rs1/2, d_use_rs1/2, d_rd,
//     d_rf_we, d_is_load, d_is_mem        - D-stage instruction attributes
//     x_br_taken, x_jal, x_jalr           - redirect resolved in X
//     dmem_ready                          - W-stage memory access complete
//     stall_if, stall_d, stall_x          - hold PC / D reg / X reg
//     flush_d                             - make the D->X transfer a bubble
//     fwd_a_sel, fwd_b_sel                - 0 regfile, 1 X result, 2 W data
//     mem_err                             - sticky memory-timeout flag
//   Build option HAZARD_FWD_EN: enables operand forwarding; without it every
//   RAW dependency on X or W is resolved by stalling.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_use_rs1,
    input  logic              d_use_rs2,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_rf_we,
    input  logic              d_is_load,
    input  logic              d_is_mem,
    input  logic              x_br_taken,
    input  logic              x_jal,
    input  logic              x_jalr,
    input  logic              dmem_ready,
    output logic              stall_if,
    output logic              stall_d,
    output logic              stall_x,
    output logic              flush_d,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              mem_err
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [TMO_W-1:0]       TMO_LIMIT  = TMO_W'(MEM_TIMEOUT);

    sh_flags_t         x_f, w_f;
    logic [REG_AW-1:0] x_rd, w_rd;

    hz_state_e                state, ret_state, eff_state;
    logic [FLUSH_CNT_W-1:0]   flush_left;
    logic                     redir_pend;
    logic [TMO_W-1:0]         tmo_cnt, tmo_next;

    logic freeze, redirect_req, raw_stall;
    logic a_hit, b_hit;
    logic w_load_unused;

    // Forwarding from W is identical for loads and ALU ops
    assign w_load_unused = w_f.load;

    hazard_fwd_match #(.REG_AW(REG_AW)) u_match_a (
        .use_rs (d_use_rs1), .rs (d_rs1),
        .x_valid(x_f.valid), .x_we(x_f.we), .x_load(x_f.load), .x_rd(x_rd),
        .w_valid(w_f.valid), .w_we(w_f.we), .w_rd(w_rd),
        .sel    (fwd_a_sel), .raw_hit(a_hit)
    );

    hazard_fwd_match #(.REG_AW(REG_AW)) u_match_b (
        .use_rs (d_use_rs2), .rs (d_rs2),
        .x_valid(x_f.valid), .x_we(x_f.we), .x_load(x_f.load), .x_rd(x_rd),
        .w_valid(w_f.valid), .w_we(w_f.we), .w_rd(w_rd),
        .sel    (fwd_b_sel), .raw_hit(b_hit)
    );

    assign freeze       = w_f.valid && w_f.mem && !dmem_ready;
    // A redirect seen during a freeze is remembered and acted on at unfreeze
    assign redirect_req = x_br_taken || x_jal || x_jalr || redir_pend;
    assign raw_stall    = d_valid && (a_hit || b_hit);
    // Leaving MEMWAIT behaves as the saved state in that same cycle
    assign eff_state    = (state == MEMWAIT) ? ret_state : state;
    assign tmo_next     = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;

    // Priority: freeze > redirect / flush window > RAW stall
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        stall_if = 1'b0;
        stall_d  = 1'b0;
        stall_x  = 1'b0;
        flush_d  = 1'b0;
        if (freeze) begin
            stall_if = 1'b1;
            stall_d  = 1'b1;
            stall_x  = 1'b1;
        end else if (redirect_req || eff_state == FLUSH) begin
            // The dependent D instruction is squashed, so no stall is needed
            flush_d = 1'b1;
        end else if (raw_stall) begin
            stall_if = 1'b1;
            stall_d  = 1'b1;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            ret_state  <= RUN;
            flush_left <= '0;
            redir_pend <= 1'b0;
            tmo_cnt    <= '0;
            mem_err    <= 1'b0;
            x_f        <= '0;
            w_f        <= '0;
            x_rd       <= '0;
            w_rd       <= '0;
        end else if (freeze) begin
            // Whole pipe holds; shadows and flush countdown are untouched
            if (state != MEMWAIT) begin
                ret_state <= state;
            end
            state      <= MEMWAIT;
            redir_pend <= redirect_req;
            tmo_cnt    <= tmo_next;
            if (tmo_next == TMO_LIMIT) begin
                mem_err <= 1'b1;
            end
        end else begin
            tmo_cnt    <= '0;
            redir_pend <= 1'b0;

            if (d_valid && !stall_d && !flush_d) begin
                x_f.valid <= 1'b1;
                x_f.we    <= d_rf_we && (d_rd != '0);
                x_f.load  <= d_is_load;
                x_f.mem   <= d_is_mem;
                x_rd      <= d_rd;
            end else begin
                x_f <= '0;
            end
            w_f  <= x_f;
            w_rd <= x_rd;

            if (redirect_req) begin
                state      <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                flush_left <= FLUSH_INIT;
            end else if (eff_state == FLUSH) begin
                state      <= (flush_left <= 1) ? RUN : FLUSH;
                flush_left <= flush_left - 1'b1;
            end else if (raw_stall) begin
                state <= LDSTALL;
            end else begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl (FLUSH_CYCLES = 2, MEM_TIMEOUT = 255).
//   Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
//   later, well clear of the next edge. Sections that depend on forwarding
//   follow the HAZARD_FWD_EN build option.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d_valid;
    logic [4:0] d_rs1, d_rs2, d_rd;
    logic       d_use_rs1, d_use_rs2, d_rf_we, d_is_load, d_is_mem;
    logic       x_br_taken, x_jal, x_jalr, dmem_ready;
    logic       stall_if, stall_d, stall_x, flush_d, mem_err;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(
        .REG_AW(5), .FLUSH_CYCLES(2), .MEM_TIMEOUT(255)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_rd(d_rd),
        .d_rf_we(d_rf_we), .d_is_load(d_is_load), .d_is_mem(d_is_mem),
        .x_br_taken(x_br_taken), .x_jal(x_jal), .x_jalr(x_jalr),
        .dmem_ready(dmem_ready),
        .stall_if(stall_if), .stall_d(stall_d), .stall_x(stall_x),
        .flush_d(flush_d), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_valid = 1'b0; d_rs1 = '0; d_rs2 = '0; d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
        d_rd = '0; d_rf_we = 1'b0; d_is_load = 1'b0; d_is_mem = 1'b0;
        x_br_taken = 1'b0; x_jal = 1'b0; x_jalr = 1'b0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic mem);
        d_valid = 1'b1; d_rs1 = rs1; d_rs2 = rs2; d_use_rs1 = u1; d_use_rs2 = u2;
        d_rd = rd; d_rf_we = we; d_is_load = ld; d_is_mem = mem;
    endtask

    task automatic drain();
        idle();
        tick();
        tick();
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        idle();
        dmem_ready = 1'b1;
        #3;
        chk1("rst_stall_if", stall_if, 1'b0);
        chk1("rst_stall_d",  stall_d,  1'b0);
        chk1("rst_stall_x",  stall_x,  1'b0);
        chk1("rst_flush_d",  flush_d,  1'b0);
        chk2("rst_fwd_a",    fwd_a_sel, 2'd0);
        chk2("rst_fwd_b",    fwd_b_sel, 2'd0);
        chk1("rst_mem_err",  mem_err,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- back-to-back ALU dependency ----------------
`ifdef HAZARD_FWD_EN
        instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5
        tick();
        instr(5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6, x5
        #1;
        chk2("alu_fwd_x",      fwd_a_sel, 2'd1);
        chk1("alu_no_stall",   stall_d,   1'b0);
        tick();
        instr(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);   // reads x5
        #1;
        chk2("alu_fwd_w",      fwd_a_sel, 2'd2);
        chk1("alu_w_no_stall", stall_if,  1'b0);
        tick();
        drain();
        // X beats W when both hold x5; both operands see it
        instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        instr(5'd5, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        chk2("prio_fwd_a_x", fwd_a_sel, 2'd1);
        chk2("prio_fwd_b_x", fwd_b_sel, 2'd1);
        tick();
        drain();
`else
        instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // add x3
        tick();
        instr(5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);   // reads x3
        #1;
        chk1("raw_c1_stall_d",  stall_d,   1'b1);
        chk1("raw_c1_stall_if", stall_if,  1'b1);
        chk2("raw_fwd_tied",    fwd_a_sel, 2'd0);
        tick();
        chk1("raw_c2_stall_d",  stall_d,   1'b1);
        tick();
        chk1("raw_c3_released", stall_d,   1'b0);
        tick();
        drain();
`endif

        // ---------------- load-use ----------------
        instr(5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);   // lw x7
        tick();
        instr(5'd0, 5'd7, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);   // reads x7 as rs2
        #1;
        chk1("lu_stall_if", stall_if, 1'b1);
        chk1("lu_stall_d",  stall_d,  1'b1);
        chk1("lu_stall_x",  stall_x,  1'b0);
        chk1("lu_flush_d",  flush_d,  1'b0);
        tick();
`ifdef HAZARD_FWD_EN
        chk1("lu_next_no_stall", stall_d,   1'b0);
        chk2("lu_next_fwd_w",    fwd_b_sel, 2'd2);
`else
        chk1("lu_next_raw_stall", stall_d,  1'b1);
        chk2("lu_next_fwd_tied",  fwd_b_sel, 2'd0);
`endif
        tick();
        drain();

        // ---------------- redirect beats load-use ----------------
        instr(5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);   // lw x7
        tick();
        instr(5'd0, 5'd7, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        x_jal = 1'b1;
        #1;
        chk1("jal_flush_c1",    flush_d,  1'b1);
        chk1("jal_no_stall_if", stall_if, 1'b0);
        chk1("jal_no_stall_d",  stall_d,  1'b0);
        tick();
        x_jal = 1'b0;
        instr(5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        #1;
        chk1("jal_flush_c2",    flush_d,  1'b1);
        chk1("jal_c2_stall_if", stall_if, 1'b0);
        tick();
        idle();
        #1;
        chk1("jal_flush_done",  flush_d,  1'b0);
        tick();
        drain();

        // ---------------- freeze with held redirect ----------------
        instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);   // sw
        tick();
        instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);  // add x10
        tick();
        instr(5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0); // reads x10
        dmem_ready = 1'b0;
        #1;
        chk1("frz1_stall_if", stall_if, 1'b1);
        chk1("frz1_stall_d",  stall_d,  1'b1);
        chk1("frz1_stall_x",  stall_x,  1'b1);
        chk1("frz1_flush_d",  flush_d,  1'b0);
`ifdef HAZARD_FWD_EN
        chk2("frz1_fwd_x",    fwd_a_sel, 2'd1);
`endif
        tick();
        x_br_taken = 1'b1;
        #1;
        chk1("frz2_stall_x",  stall_x,  1'b1);
        chk1("frz2_flush_held", flush_d, 1'b0);
        tick();
        x_br_taken = 1'b0;
        #1;
        chk1("frz3_stall_x",  stall_x,  1'b1);
`ifdef HAZARD_FWD_EN
        chk2("frz3_fwd_x_held", fwd_a_sel, 2'd1);
`endif
        tick();
        dmem_ready = 1'b1;
        #1;
        chk1("unfrz_flush",    flush_d,  1'b1);
        chk1("unfrz_stall_x",  stall_x,  1'b0);
        chk1("unfrz_stall_if", stall_if, 1'b0);
        chk1("unfrz_stall_d",  stall_d,  1'b0);
        tick();
        chk1("unfrz_flush_c2", flush_d,  1'b1);
        tick();
        chk1("unfrz_flush_end", flush_d, 1'b0);
        chk1("unfrz_no_raw",    stall_d, 1'b0);
        drain();

        // ---------------- memory timeout ----------------
        instr(5'd1, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1, 1'b1);  // lw x12
        tick();
        idle();
        tick();
        dmem_ready = 1'b0;
        #1;
        chk1("tmo_freeze", stall_x, 1'b1);
        for (int k = 1; k <= 255; k++) begin
            if (k == 1 || k == 255) begin
                chk1($sformatf("tmo_no_err_k%0d", k), mem_err, 1'b0);
            end
            tick();
        end
        chk1("tmo_err_set",    mem_err, 1'b1);
        chk1("tmo_still_frz",  stall_x, 1'b1);
        dmem_ready = 1'b1;
        #1;
        chk1("tmo_err_ready",  mem_err, 1'b1);
        chk1("tmo_unfrozen",   stall_x, 1'b0);
        tick();
        chk1("tmo_err_sticky", mem_err, 1'b1);
        drain();

        // second freeze with a pending redirect, then async reset
        instr(5'd1, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b1, 1'b1);  // lw x13
        tick();
        idle();
        tick();
        dmem_ready = 1'b0;
        x_jal = 1'b1;
        #1;
        chk1("pend_frozen_no_flush", flush_d, 1'b0);
        tick();
        x_jal = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk1("arst_mem_err", mem_err, 1'b0);
        chk1("arst_stall_x", stall_x, 1'b0);
        chk1("arst_flush_d", flush_d, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        dmem_ready = 1'b1;
        #1;
        chk1("arst_no_pending", flush_d, 1'b0);
        tick();

        // ---------------- rd = 0 writer ----------------
        instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);   // add x0
        tick();
        instr(5'd0, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);   // reads x0
        #1;
        chk2("x0_fwd_a",    fwd_a_sel, 2'd0);
        chk1("x0_no_stall", stall_d,   1'b0);
        tick();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard scheduler for the 3-stage RISC-V core: D (decode/regfile read), X (execute/branch resolve), W (memory return/writeback).
- Tracks the rd / write-enable / load / memory attributes of the instructions in X and W in its own shadow registers.
- Generates operand-forwarding selects, load-use stalls, branch/jump flush bubbles, and a full-pipe freeze while data memory is not ready.

Parameters:
REG_AW, 5, register-address width
FLUSH_CYCLES, 1, bubbles inserted into X after a redirect (1..3)
MEM_TIMEOUT, 255, consecutive freeze cycles before mem_err sets (8-bit counter)

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
d_valid  in  1  valid instruction in D
d_rs1, d_rs2  in  REG_AW  source registers of D instruction
d_use_rs1, d_use_rs2  in  1  D instruction reads that source
d_rd  in  REG_AW  destination of D instruction
d_rf_we  in  1  D instruction writes rd
d_is_load  in  1  D instruction is a load
d_is_mem  in  1  D instruction is a load or store
x_br_taken, x_jal, x_jalr  in  1  redirect resolved in X this cycle
dmem_ready  in  1  data memory has completed the W access
stall_if, stall_d, stall_x  out  1  hold PC / D register / X register
flush_d  out  1  turn the D→X transfer into a bubble
fwd_a_sel, fwd_b_sel  out  2  0 = regfile, 1 = X ALU result, 2 = W writeback data
mem_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset (async, rst_n low):
  - X/W shadows invalid, state RUN, counters 0.
  - All outputs 0.
- Shadow entry {valid, rd, we, load, mem}:
  - we is forced to 0 when rd == 0.
  - On an unfrozen cycle: X shadow ← D fields if d_valid && !stall_d && !flush_d, else a bubble; W shadow ← X shadow.
  - On a frozen cycle: both shadows hold.
- Forwarding (combinational, per operand, only when use_rsN && rsN != 0):
  - sel = 1 if X.valid && X.we && !X.load && X.rd == rsN.
  - else sel = 2 if W.valid && W.we && W.rd == rsN.
  - else sel = 0. X has priority over W.
- Load-use:
  - Condition: X.valid && X.load && X.we && X.rd matches a used source.
  - Response: stall_if = stall_d = 1 and a bubble into X for exactly 1 cycle. The next cycle forwards from W (sel = 2).
- Redirect (x_br_taken | x_jal | x_jalr on an unfrozen cycle):
  - flush_d = 1 in the same cycle.
  - Enter FLUSH for FLUSH_CYCLES−1 further cycles; flush_d stays 1 there.
  - The PC is not stalled.
  - Redirect beats load-use: the stall is dropped because the dependent instruction is squashed.
- Freeze:
  - Condition: W.valid && W.mem && !dmem_ready.
  - Response: stall_if = stall_d = stall_x = 1; flush_d = 0. A redirect is held until unfreeze and then acted on.
- FSM states and transitions:
  - RUN → LDSTALL on load-use → RUN next cycle.
  - RUN/LDSTALL → FLUSH on redirect. FLUSH counts down to RUN; when FLUSH_CYCLES = 1, the FSM goes straight back to RUN.
  - Any state → MEMWAIT on freeze, saving the return state. MEMWAIT → saved state when dmem_ready = 1.
  - Freeze has the highest priority.
- Timeout counter:
  - Increments each MEMWAIT cycle and clears on exit.
  - When it reaches MEM_TIMEOUT, mem_err is set (sticky until reset) and the freeze continues.
  - The counter saturates and does not wrap.
- Reset mid-freeze or mid-flush: everything returns to reset values immediately; no pending redirect survives.

Optional Feature:
HAZARD_FWD_EN
- Defined: forwarding active as described.
- Undefined:
  - fwd_*_sel are tied to 0.
  - Any used-source match against a valid X or W writer holds stall_if/stall_d and injects bubbles until both shadows are clear of that rd (up to 2 cycles).
  - LDSTALL is merged into this generic RAW stall.

Decomposition:
- Shared header, alongside the opcode defines:
  - FWD_NONE/FWD_X/FWD_W encodings.
  - FSM state encodings RUN/LDSTALL/FLUSH/MEMWAIT.
  - Shadow-entry field widths.
- One sub-module, hazard_fwd_match: a per-operand comparator producing its sel and raw-hit signals, instantiated for rs1 and rs2.

Test Plan:
- Back-to-back ALU instructions: X: add x5 (we), D: rs1 = 5, use_rs1 → fwd_a_sel = 1 and no stall; one cycle later, with x5 in W and no X match → fwd_a_sel = 2.
- Load-use: X: lw x7, D: rs2 = 7 → stall_if = stall_d = 1 for 1 cycle, X shadow becomes a bubble, next cycle fwd_b_sel = 2.
- x_jal = 1 with FLUSH_CYCLES = 2 → flush_d = 1 for 2 cycles and stall_if = 0; a simultaneous load-use produces no stall.
- W holds sw and dmem_ready is low for 3 cycles → all stalls = 1 for 3 cycles and shadows unchanged; a redirect raised during the freeze flushes on the first ready cycle.
- dmem_ready held low for 255 cycles → mem_err = 1 at cycle 255 and stays 1 after ready; pulsing rst_n low clears it asynchronously.
- rd = 0 writer in X with D rs1 = 0 → fwd_a_sel = 0 and no stall; without HAZARD_FWD_EN, add x3 followed by a reader of x3 → 2-cycle stall.
